bist_vector_driver: RTL and testbench
=====================================

Name: bist_vector_driver

Overview:
- Sequential stimulus/response harness for the combinational benchmark netlists in this suite (e.g. 28-input/3-output cones).
- Sits on the benchmark's port boundary, facing the opposite direction: it drives the IN_W primary inputs and collects the OUT_W primary outputs.
- Generates pseudo-random vectors with an LFSR and compacts responses into a MISR signature.
- Reports done/pass against a golden signature through a start/done handshake.

Parameters:
- IN_W, 28, width of vector driven into the DUT primary inputs (1..32).
- OUT_W, 3, width of DUT response (1..SIG_W).
- NUM_VECTORS, 1024, vectors applied per run (>=1).
- SEED, 32'h00000001, LFSR load value; a value of 0 is replaced by 1.
- TAPS, 32'h80200003, Fibonacci feedback tap mask for the 32-bit LFSR.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- RESP_LAT, 0, cycles between vector presentation and response sampling (0..7).
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin run; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns to IDLE.
- vec_out  out  IN_W  stimulus to DUT = lfsr[IN_W-1:0].
- vec_valid  out  1  high while vec_out carries a counted vector.
- resp_in  in  OUT_W  DUT response.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid when done: signature==GOLDEN.
- signature  out  SIG_W  current MISR contents.

Behaviour:
- Reset: state=IDLE. lfsr=0, vec_out=0, vec_valid=0, busy=0, done=0, pass=0, signature=0, counters=0.
- States:
  - IDLE: start=1 -> lfsr<=SEED (or 1), sig<=0, cnt<=0 -> RUN.
  - RUN: vec_valid=1. Each edge: lfsr<={lfsr[30:0], ^(lfsr&TAPS)}, cnt++. When cnt==NUM_VECTORS-1 at the edge -> DRAIN (or DONE if RESP_LAT==0).
  - DRAIN: vec_valid=0, lfsr holds. Stay exactly RESP_LAT cycles -> DONE.
  - DONE: done=1, pass=(sig==GOLDEN), both registered. start=1 -> same reload as IDLE -> RUN, done drops next cycle.
- Capture strobe = vec_valid delayed by RESP_LAT flops (RESP_LAT=0: vec_valid itself). Vector k is presented in RUN cycle k and its response is sampled at the end of cycle k+RESP_LAT.
- MISR update on strobe: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp_in.
- Latency: start sampled at edge 0; vec_valid high for cycles 1..N; done rises at edge N+RESP_LAT+1.
- start while busy: ignored.
- abort: priority over start in every state. -> IDLE, clears vec_valid and the strobe pipeline, done=0, pass=0. Signature holds its last value.
- abort and start in the same cycle in IDLE: abort wins, stays IDLE.
- Reset mid-run: immediate return to reset values; no partial done.
- Counter width is clog2(NUM_VECTORS+1); no wrap inside a run.
- The LFSR never reaches zero from a non-zero seed with the default taps.

Optional Feature:
- Macro: BIST_RESP_MASK_EN.
- Defined: adds input port resp_mask [OUT_W-1:0]. MISR compacts resp_in & ~resp_mask; mask bits set to 1 exclude unknown or don't-care outputs. The mask is sampled with the same RESP_LAT alignment as resp_in.
- Undefined: no port; all response bits are compacted.

Test Plan:
- Reset: assert reset mid-RUN -> all outputs 0 asynchronously; after release the block sits in IDLE with busy=0.
- Vector sequence: SEED=1, NUM_VECTORS=4, RESP_LAT=0, start pulse -> vec_out 0x0000001, 0x0000003, 0x0000006, 0x000000D on cycles 1-4; vec_valid high exactly 4 cycles; done at edge 5.
- MISR constant input: NUM_VECTORS=3, resp_in=3'b001 held -> signature 0x0001, 0x0003, 0x0007; with GOLDEN=16'h0007, pass=1. With resp_in=0 -> signature 0x0000, and pass=1 only when GOLDEN=0.
- Latency: RESP_LAT=2, NUM_VECTORS=4 -> strobe high on cycles 3-6, busy high for 6 cycles, done at edge 7. Response injected only on cycle 1 is not compacted.
- Handshake: start held high throughout a run -> no restart while busy; a new run begins the cycle after DONE is entered. abort during RUN -> IDLE next edge, done never asserts.
- BIST_RESP_MASK_EN: resp_in=3'b111, resp_mask=3'b110, NUM_VECTORS=3 -> signature 0x0007, identical to the unmasked 3'b001 case.

Source files
------------

// File: rtl/bist_vector_driver.sv
// LFSR stimulus driver and MISR response compactor for combinational benchmark cones.
// Optional BIST_RESP_MASK_EN adds resp_mask; set bits are excluded from compaction.
module bist_vector_driver #(
   parameter int              IN_W        = 28,
   parameter int              OUT_W       = 3,
   parameter int              NUM_VECTORS = 1024,
   parameter logic [31:0]     SEED        = 32'h00000001,
   parameter logic [31:0]     TAPS        = 32'h80200003,
   parameter int              SIG_W       = 16,
   parameter logic [SIG_W-1:0] POLY       = 16'h1021,
   parameter int              RESP_LAT    = 0,
   parameter logic [SIG_W-1:0] GOLDEN     = 16'h0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  vec_out,
   output logic             vec_valid,
   input  logic [OUT_W-1:0] resp_in,
`ifdef BIST_RESP_MASK_EN
   input  logic [OUT_W-1:0] resp_mask,
`endif
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int           CW       = $clog2(NUM_VECTORS + 1);
   localparam logic [31:0]  SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [CW-1:0] LAST    = CW'(NUM_VECTORS - 1);
   localparam logic [2:0]   DLAST    = 3'(RESP_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              load;
   logic [31:0]       lfsr;
   logic [CW-1:0]     cnt;
   logic [2:0]        dcnt;
   logic              strobe;
   logic [OUT_W-1:0]  resp_eff;
   logic [SIG_W-1:0]  sig_next;

`ifdef BIST_RESP_MASK_EN
   assign resp_eff = resp_in & ~resp_mask;
`else
   assign resp_eff = resp_in;
`endif

   assign vec_out   = lfsr[IN_W-1:0];
   assign vec_valid = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign sig_next  = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(resp_eff);

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: if (start) begin
               state_d = S_RUN;
               load    = 1'b1;
            end
            S_RUN:   if (cnt == LAST) state_d = (RESP_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (dcnt == DLAST) state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         lfsr      <= '0;
         cnt       <= '0;
         dcnt      <= '0;
         signature <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         state_q <= state_d;
         // done/pass are registered a cycle into DONE so they see the final signature
         done    <= (state_q == S_DONE) && (state_d == S_DONE);
         pass    <= (state_q == S_DONE) && (state_d == S_DONE) && (signature == GOLDEN);
         if (load) begin
            lfsr <= SEED_EFF;
            cnt  <= '0;
         end else if (state_q == S_RUN && !abort) begin
            lfsr <= {lfsr[30:0], ^(lfsr & TAPS)};
            cnt  <= cnt + 1'b1;
         end
         dcnt <= (state_q == S_DRAIN && !abort) ? dcnt + 3'd1 : 3'd0;
         if (load)
            signature <= '0;
         else if (strobe && !abort)
            signature <= sig_next;
      end
   end

   // Capture strobe: vec_valid delayed to line up with the DUT's response latency
   generate
      if (RESP_LAT == 0) begin : g_nolat
         assign strobe = vec_valid;
      end else begin : g_lat
         logic [RESP_LAT-1:0] vld_pipe;
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               vld_pipe <= '0;
            end else if (abort) begin
               vld_pipe <= '0;
            end else begin
               vld_pipe[0] <= vec_valid;
               for (int i = 1; i < RESP_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
         end
         assign strobe = vld_pipe[RESP_LAT-1];
      end
   endgenerate

endmodule

// File: tb/tb_bist_vector_driver.sv
// Directed bench: three driver configurations share clock/reset/start/abort.
module tb_bist_vector_driver;

   logic        clock = 1'b0;
   logic        reset, start, abort;
   logic [2:0]  resp0, resp1, resp2, mask0, mask1, mask2;
   logic [27:0] vo0, vo1, vo2;
   logic        vv0, vv1, vv2, busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
   logic [15:0] sig0, sig1, sig2;
   int          n_chk = 0, n_err = 0;

   always #5 clock = ~clock;

   // u0: sequence/handshake, u1: MISR constant input, u2: response latency
   bist_vector_driver #(.NUM_VECTORS(4), .RESP_LAT(0), .GOLDEN(16'h0000)) u0 (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .vec_out(vo0), .vec_valid(vv0),
      .resp_in(resp0),
`ifdef BIST_RESP_MASK_EN
      .resp_mask(mask0),
`endif
      .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));

   bist_vector_driver #(.NUM_VECTORS(3), .RESP_LAT(0), .GOLDEN(16'h0007)) u1 (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .vec_out(vo1), .vec_valid(vv1),
      .resp_in(resp1),
`ifdef BIST_RESP_MASK_EN
      .resp_mask(mask1),
`endif
      .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

   bist_vector_driver #(.NUM_VECTORS(4), .RESP_LAT(2), .GOLDEN(16'h0000)) u2 (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .vec_out(vo2), .vec_valid(vv2),
      .resp_in(resp2),
`ifdef BIST_RESP_MASK_EN
      .resp_mask(mask2),
`endif
      .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      resp0 = 3'b000; resp2 = 3'b000; mask0 = 3'b000; mask2 = 3'b000;
`ifdef BIST_RESP_MASK_EN
      resp1 = 3'b111; mask1 = 3'b110;
`else
      resp1 = 3'b001; mask1 = 3'b000;
`endif
      #2;
      chk("rst_vec_out", vo0, 0);
      chk("rst_vec_valid", vv0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_sig", sig1, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("idle_busy", busy0, 0);
      chk("idle_vec_valid", vv0, 0);

      // run 1: start at edge 0
      start = 1'b1; tick(); start = 1'b0;
      resp2 = 3'b111;                        // only in cycle 1: must not be compacted by u2
      chk("c1_vec", vo0, 28'h0000001);
      chk("c1_valid", vv0, 1);
      chk("c1_busy_lat", busy2, 1);
      tick(); resp2 = 3'b000;
      chk("c2_vec", vo0, 28'h0000003);
      chk("c2_sig_misr", sig1, 16'h0001);
      tick();
      chk("c3_vec", vo0, 28'h0000006);
      chk("c3_sig_misr", sig1, 16'h0003);
      tick();
      chk("c4_vec", vo0, 28'h000000D);
      chk("c4_valid", vv0, 1);
      chk("c4_sig_misr", sig1, 16'h0007);
      chk("c4_misr_busy", busy1, 0);
      chk("c4_misr_done", done1, 0);
      tick();
      chk("c5_valid", vv0, 0);
      chk("c5_busy", busy0, 0);
      chk("c5_done_early", done0, 0);
      chk("c5_misr_done", done1, 1);
      chk("c5_misr_pass", pass1, 1);
      chk("c5_lat_busy", busy2, 1);
      tick();
      chk("c6_done", done0, 1);
      chk("c6_pass", pass0, 1);
      chk("c6_lat_busy", busy2, 1);
      chk("c6_lat_done", done2, 0);
      tick();
      chk("c7_lat_busy", busy2, 0);
      chk("c7_lat_done", done2, 0);
      tick();
      chk("c8_lat_done", done2, 1);
      chk("c8_lat_sig", sig2, 0);
      chk("c8_lat_pass", pass2, 1);

      // run 2: start held high through the whole run
      start = 1'b1; tick();
      chk("r2_done_drop", done0, 0);
      chk("r2_busy", busy0, 1);
      chk("r2_reload_vec", vo0, 28'h0000001);
      chk("r2_reload_sig", sig1, 0);
      tick(); tick(); tick();
      chk("r2_no_restart", vo0, 28'h000000D);
      tick();
      chk("r2_done_state_busy", busy0, 0);
      tick();
      chk("r2_restart_busy", busy0, 1);
      chk("r2_restart_vec", vo0, 28'h0000001);
      start = 1'b0;
      tick();
      chk("r3_vec", vo0, 28'h0000003);
      chk("r3_misr_sig", sig1, 16'h0003);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort_busy", busy0, 0);
      chk("abort_valid", vv0, 0);
      chk("abort_sig_hold", sig1, 16'h0003);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("abort_no_done", done0, 0);
      end

      // abort beats start in IDLE
      abort = 1'b1; start = 1'b1; tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_start_idle", busy0, 0);
      tick();
      chk("abort_start_idle2", busy0, 0);

      // asynchronous reset mid-run
      start = 1'b1; tick(); start = 1'b0; tick();
      chk("pre_rst_busy", busy0, 1);
      chk("pre_rst_sig", sig1, 16'h0001);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_busy", busy0, 0);
      chk("async_rst_vec", vo0, 0);
      chk("async_rst_valid", vv0, 0);
      chk("async_rst_sig", sig1, 0);
      tick(); reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_busy", busy0, 0);
         chk("post_rst_done", done0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
